// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter: a rotating priority pointer selects among SIZE requesters,
// and the grant is held until the consumer accepts it.
module round_robin_arbiter #(
    parameter int SIZE        = 4,
    parameter int INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [SIZE-1:0]        requests,
    output logic [SIZE-1:0]        grant,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_index,
    input  logic                   grant_accept
);

    // Handshake: a grant is offered while grant_valid=1 and is consumed on any
    // rising edge where grant_accept=1; grant_accept is ignored while grant_valid=0.

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [SIZE-1:0]        grant_next;
    logic [INDEX_WIDTH-1:0] index_next;
    logic [INDEX_WIDTH-1:0] pointer, pointer_next;
    logic [INDEX_WIDTH-1:0] arb_pointer;
    logic [SIZE-1:0]        mask;
    logic [SIZE-1:0]        masked_winner;
    logic [SIZE-1:0]        winner;
    logic [INDEX_WIDTH-1:0] winner_index;
    logic                   accept;

    // Isolates the lowest set bit (two's-complement trick).
    function automatic logic [SIZE-1:0] first_one(input logic [SIZE-1:0] value);
        return value & (~value + SIZE'(1));
    endfunction

    assign accept = (state == GRANTED) && grant_accept;

    // On accept, arbitration already uses the pointer rotated past the holder.
    always_comb begin
        arb_pointer = pointer;
        if (accept) begin
            if (grant_index == INDEX_WIDTH'(SIZE - 1)) begin
                arb_pointer = '0;
            end else begin
                arb_pointer = grant_index + INDEX_WIDTH'(1);
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            mask[i] = (INDEX_WIDTH'(i) >= arb_pointer);
        end
        masked_winner = first_one(requests & mask);
        if (masked_winner != '0) begin
            winner = masked_winner;
        end else begin
            winner = first_one(requests);
        end
        winner_index = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (winner[i]) begin
                winner_index = INDEX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        index_next   = grant_index;
        pointer_next = pointer;
        case (state)
            IDLE: begin
                if (winner != '0) begin
                    state_next = GRANTED;
                    grant_next = winner;
                    index_next = winner_index;
                end
            end
            GRANTED: begin
                if (grant_accept) begin
                    pointer_next = arb_pointer;
                    if (winner != '0) begin
                        grant_next = winner;
                        index_next = winner_index;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                        index_next = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                index_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            grant       <= '0;
            grant_index <= '0;
            pointer     <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            grant_index <= index_next;
            pointer     <= pointer_next;
        end
    end

    assign grant_valid = (state == GRANTED);

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter (SIZE=4): reset, rotation, hold, wrap,
// fallback path, ignored idle accepts and asynchronous reset mid-grant.
module tb_round_robin_arbiter;

    localparam int SIZE = 4;
    localparam int IW   = 2;

    logic            clock;
    logic            resetn;
    logic [SIZE-1:0] requests;
    logic [SIZE-1:0] grant;
    logic            grant_valid;
    logic [IW-1:0]   grant_index;
    logic            grant_accept;

    int n_checks;
    int n_fail;

    round_robin_arbiter #(.SIZE(SIZE)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .requests    (requests),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .grant_accept(grant_accept)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        requests     = '0;
        grant_accept = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        resetn       = 1'b0;
        requests     = '0;
        grant_accept = 1'b0;
        #12;
        exp = 7'b0000_0_00;
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL reset_hold: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({grant, grant_valid, grant_index} !== exp) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: got %b required %b", c, {grant, grant_valid, grant_index}, exp);
            end
        end
    endtask

    task automatic test_rotation();
        logic [6:0] exp_seq [5];
        exp_seq[0] = {4'b0001, 1'b1, 2'd0};
        exp_seq[1] = {4'b0010, 1'b1, 2'd1};
        exp_seq[2] = {4'b0100, 1'b1, 2'd2};
        exp_seq[3] = {4'b1000, 1'b1, 2'd3};
        exp_seq[4] = {4'b0001, 1'b1, 2'd0};
        do_reset();
        requests     = 4'b1111;
        grant_accept = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({grant, grant_valid, grant_index} !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL rotation_%0d: got %b required %b", k, {grant, grant_valid, grant_index}, exp_seq[k]);
            end
        end
        requests = '0;
        tick();
        n_checks++;
        if ({grant, grant_valid, grant_index} !== 7'b0000_0_00) begin
            n_fail++;
            $display("FAIL rotation_drain: got %b required %b", {grant, grant_valid, grant_index}, 7'b0000_0_00);
        end
    endtask

    task automatic test_hold_and_wrap();
        logic [6:0] exp;
        do_reset();
        requests = 4'b1010;
        tick();
        exp = {4'b0010, 1'b1, 2'd1};
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL hold_first: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
        requests = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({grant, grant_valid, grant_index} !== exp) begin
                n_fail++;
                $display("FAIL hold_cycle_%0d: got %b required %b", c, {grant, grant_valid, grant_index}, exp);
            end
        end
        grant_accept = 1'b1;
        tick();
        exp = {4'b1000, 1'b1, 2'd3};
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL hold_accept: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
        requests = 4'b1001;
        tick();
        exp = {4'b0001, 1'b1, 2'd0};
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL wrap: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
        requests = '0;
        tick();
        n_checks++;
        if ({grant, grant_valid, grant_index} !== 7'b0000_0_00) begin
            n_fail++;
            $display("FAIL wrap_drain: got %b required %b", {grant, grant_valid, grant_index}, 7'b0000_0_00);
        end
    endtask

    // Pointer is 1 on entry; accepting index 2 moves it to 3, leaving only the fallback path.
    task automatic test_single_fallback();
        logic [6:0] exp;
        exp          = {4'b0100, 1'b1, 2'd2};
        requests     = 4'b0100;
        grant_accept = 1'b0;
        tick();
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL single_first: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
        grant_accept = 1'b1;
        tick();
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL single_back_to_back: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
        requests = '0;
        tick();
        n_checks++;
        if ({grant, grant_valid, grant_index} !== 7'b0000_0_00) begin
            n_fail++;
            $display("FAIL single_release: got %b required %b", {grant, grant_valid, grant_index}, 7'b0000_0_00);
        end
        requests     = 4'b0100;
        grant_accept = 1'b0;
        tick();
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL single_regrant: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
    endtask

    // Pointer is 3 after this drain; accepts while idle must not move it.
    task automatic test_idle_accept();
        logic [6:0] exp;
        requests     = '0;
        grant_accept = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        n_checks++;
        if ({grant, grant_valid, grant_index} !== 7'b0000_0_00) begin
            n_fail++;
            $display("FAIL idle_accept_quiet: got %b required %b", {grant, grant_valid, grant_index}, 7'b0000_0_00);
        end
        requests     = 4'b1111;
        grant_accept = 1'b0;
        tick();
        exp = {4'b1000, 1'b1, 2'd3};
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL idle_accept_pointer: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [6:0] exp;
        do_reset();
        requests = 4'b0100;
        tick();
        exp = {4'b0100, 1'b1, 2'd2};
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL mid_setup: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({grant, grant_valid, grant_index} !== 7'b0000_0_00) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %b required %b", {grant, grant_valid, grant_index}, 7'b0000_0_00);
        end
        requests = 4'b0110;
        #1;
        resetn = 1'b1;
        tick();
        exp = {4'b0010, 1'b1, 2'd1};
        n_checks++;
        if ({grant, grant_valid, grant_index} !== exp) begin
            n_fail++;
            $display("FAIL mid_after_release: got %b required %b", {grant, grant_valid, grant_index}, exp);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        requests     = '0;
        grant_accept = 1'b0;
        test_reset();
        test_rotation();
        test_hold_and_wrap();
        test_single_fallback();
        test_idle_accept();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
